multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle TSC decoder. FSM sequences each instruction through IF/ID/EX/MEM/WB,
//  drives per-state datapath strobes, stalls on a req/ack memory port, and counts retired instructions.
//  Sits beside the multi-cycle datapath; consumes IR opcode/func fields and produces all datapath control.
// PARAMETERS
//  OPCODE_W    4   opcode field width (IR[15:12])
//  FUNC_W      6   function field width (IR[5:0]) for opcode 15
//  NUM_INST_W  16  width of retired-instruction counter
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-high; forces IF and output reset values
//  opcode       in   OPCODE_W    IR opcode, valid from ID onward
//  func_code    in   FUNC_W      IR function field, valid from ID onward
//  mem_ack      in   1           memory completes current mem_read/mem_write this cycle
//  pc_write     out  1           load PC unconditionally
//  pc_write_cond out 1           load PC if datapath branch condition true
//  pc_source    out  2           0 ALU result, 1 branch target register, 2 jump target, 3 register (JPR/JRL)
//  ir_write     out  1           latch fetched word into IR
//  i_or_d       out  1           memory address: 0 PC, 1 ALU-out
//  mem_read     out  1           memory read request (held until mem_ack)
//  mem_write    out  1           memory write request (held until mem_ack)
//  mem_to_reg   out  1           writeback source: 0 ALU-out, 1 MDR
//  reg_dst      out  2           0 rt, 1 rd, 2 r2 (link)
//  reg_write    out  1           register-file write enable
//  alu_src_a    out  1           0 PC, 1 rs
//  alu_src_b    out  2           0 rt, 1 constant 1, 2 sign/zero/LHI imm, 3 branch offset
//  alu_op       out  2           0 add, 1 branch compare, 2 decode func_code, 3 decode opcode (imm)
//  is_wwd       out  1           one-cycle pulse: output port latches rs
//  inst_done    out  1           one-cycle retire pulse
//  illegal      out  1           one-cycle pulse on unknown opcode/func in ID
//  halted       out  1           sticky after HLT until reset
//  num_inst     out  NUM_INST_W  retired-instruction count
// BEHAVIOUR
//  Reset: state=IF; all strobes 0, num_inst=0, halted=0; an in-flight request is dropped immediately.
//  Outputs are Moore (state plus latched opcode/func) except pc_write/ir_write in IF and inst_done in MEM,
//    which qualify on mem_ack. Every strobe not listed for a state is 0.
//  IF: mem_read=1, i_or_d=0. Stay in IF while !mem_ack.
//    On mem_ack: ir_write=1, pc_write=1, pc_source=0, alu_src_a=0, alu_src_b=1, alu_op=0 (PC+1); go to ID.
//  ID: alu_src_a=0, alu_src_b=3 (precompute branch target). Then by opcode/func:
//    JMP(9): pc_write, pc_source=2; retire.
//    JAL(10): as JMP plus reg_write, reg_dst=2, mem_to_reg=0; retire.
//    JPR(15/25): pc_write, pc_source=3; retire.  JRL(15/26): as JPR plus link write as JAL; retire.
//    WWD(15/28): is_wwd=1; retire.
//    HLT(15/29): go to HALT; retire.
//    Unknown: illegal=1; retire as NOP.
//    All others: go to EX.
//  EX: alu_src_a=1.
//    R-type(15/0..7): alu_src_b=0, alu_op=2; go to WB.
//    ADI(4), ORI(5), LHI(6): alu_src_b=2, alu_op=3; go to WB.
//    LWD(7), SWD(8): alu_src_b=2, alu_op=0; go to MEM.
//    BNE/BEQ/BGZ/BLZ(0..3): alu_op=1, pc_write_cond=1, pc_source=1; retire.
//  MEM: i_or_d=1; mem_read=1 (LWD) or mem_write=1 (SWD). Stay in MEM while !mem_ack.
//    On ack: LWD goes to WB; SWD retires (inst_done asserted in the ack cycle).
//  WB: reg_write=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 only for LWD; retire.
//  Retire: inst_done=1, num_inst+=1 (wraps to 0 at max); next state IF.
//  HALT: all strobes 0, halted=1. Stay until reset; mem_ack ignored.
//  mem_ack outside IF/MEM is ignored. ack may arrive in the same cycle as the request (zero-wait).
//  Zero-wait latency in cycles: ADD/ADI 4; LWD 5; SWD 4; branch 3; JMP/JAL/JPR/WWD/HLT 2.
// TESTING
//  Zero-wait ADD (op15/f0) -> states IF,ID,EX,WB; reg_write=1 and reg_dst=1 only in WB; inst_done at cycle 4; num_inst=1.
//  LWD, mem_ack delayed 3 cycles in IF and in MEM -> mem_read held 4 cycles each; MEM i_or_d=1; WB mem_to_reg=1.
//  JAL then WWD -> ID cycle shows pc_source=2, reg_dst=2, reg_write=1; next ID shows is_wwd single pulse; num_inst=2.
//  BEQ (op1) -> EX asserts pc_write_cond=1, pc_source=1, alu_op=1; pc_write stays 0; retire after 3 cycles.
//  HLT, then 5 cycles of mem_ack pulses -> halted=1 sticky; no strobes; num_inst frozen.
//  reset asserted mid-MEM of SWD -> mem_write drops same cycle; state IF, num_inst=0 after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle TSC control unit: sequences IF/ID/EX/MEM/WB, drives datapath strobes,
// stalls on the req/ack memory port and counts retired instructions.
module multicycle_control_unit #(
  parameter int OPCODE_W   = 4,
  parameter int FUNC_W     = 6,
  parameter int NUM_INST_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNC_W-1:0]     func_code,
  input  logic                  mem_ack,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic [1:0]            pc_source,
  output logic                  ir_write,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic [1:0]            reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  is_wwd,
  output logic                  inst_done,
  output logic                  illegal,
  output logic                  halted,
  output logic [NUM_INST_W-1:0] num_inst
);

  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BGZ = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BLZ = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LHI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LWD = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SWD = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_RTY = OPCODE_W'(15);

  localparam logic [FUNC_W-1:0] FN_ALU_LIM = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] FN_JPR     = FUNC_W'(25);
  localparam logic [FUNC_W-1:0] FN_JRL     = FUNC_W'(26);
  localparam logic [FUNC_W-1:0] FN_WWD     = FUNC_W'(28);
  localparam logic [FUNC_W-1:0] FN_HLT     = FUNC_W'(29);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  typedef struct packed {
    logic rtype, alu_imm, lwd, swd, branch;
    logic jmp, jal, jpr, jrl, wwd, hlt, bad;
  } dec_t;

  // Only the classes that need EX/MEM/WB are carried past ID.
  typedef struct packed {
    logic rtype, alu_imm, lwd, swd, branch;
  } cls_t;

  state_t state;
  dec_t   d;
  cls_t   cls_q;
  logic   id_retire;

  always_comb begin
    d = '0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: d.branch  = 1'b1;
      OP_ADI, OP_ORI, OP_LHI:         d.alu_imm = 1'b1;
      OP_LWD:                         d.lwd     = 1'b1;
      OP_SWD:                         d.swd     = 1'b1;
      OP_JMP:                         d.jmp     = 1'b1;
      OP_JAL:                         d.jal     = 1'b1;
      OP_RTY: begin
        if (func_code < FN_ALU_LIM) d.rtype = 1'b1;
        else begin
          case (func_code)
            FN_JPR:  d.jpr = 1'b1;
            FN_JRL:  d.jrl = 1'b1;
            FN_WWD:  d.wwd = 1'b1;
            FN_HLT:  d.hlt = 1'b1;
            default: d.bad = 1'b1;
          endcase
        end
      end
      default: d.bad = 1'b1;
    endcase
  end

  assign id_retire = d.jmp | d.jal | d.jpr | d.jrl | d.wwd | d.hlt | d.bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IF;
      cls_q    <= '0;
      num_inst <= '0;
      halted   <= 1'b0;
    end else begin
      if (inst_done) num_inst <= num_inst + 1'b1;
      case (state)
        S_IF: if (mem_ack) state <= S_ID;
        S_ID: begin
          cls_q.rtype   <= d.rtype;
          cls_q.alu_imm <= d.alu_imm;
          cls_q.lwd     <= d.lwd;
          cls_q.swd     <= d.swd;
          cls_q.branch  <= d.branch;
          if (d.hlt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (id_retire) state <= S_IF;
          else                    state <= S_EX;
        end
        S_EX: begin
          if (cls_q.branch)                 state <= S_IF;
          else if (cls_q.lwd || cls_q.swd)  state <= S_MEM;
          else                              state <= S_WB;
        end
        S_MEM:   if (mem_ack) state <= cls_q.lwd ? S_WB : S_IF;
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Strobes decode from state; reset gates them so an in-flight request drops at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    is_wwd        = 1'b0;
    inst_done     = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ack) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
          end
        end
        S_ID: begin
          alu_src_b = 2'd3;
          inst_done = id_retire;
          illegal   = d.bad;
          is_wwd    = d.wwd;
          if (d.jmp || d.jal) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
          end
          if (d.jpr || d.jrl) begin
            pc_write  = 1'b1;
            pc_source = 2'd3;
          end
          if (d.jal || d.jrl) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
          end
        end
        S_EX: begin
          alu_src_a = 1'b1;
          if (cls_q.rtype) begin
            alu_op = 2'd2;
          end else if (cls_q.alu_imm) begin
            alu_src_b = 2'd2;
            alu_op    = 2'd3;
          end else if (cls_q.lwd || cls_q.swd) begin
            alu_src_b = 2'd2;
          end else if (cls_q.branch) begin
            alu_op        = 2'd1;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
            inst_done     = 1'b1;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = cls_q.lwd;
          mem_write = cls_q.swd;
          inst_done = cls_q.swd & mem_ack;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = cls_q.rtype ? 2'd1 : 2'd0;
          mem_to_reg = cls_q.lwd;
          inst_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-instruction expected strobe sequences derived from the ISA rules,
// compared every cycle, plus literal pins on latency, counts and reset behaviour.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        mem_ack;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic [1:0]  pc_source, reg_dst, alu_src_b, alu_op;
  logic        reg_write, alu_src_a, is_wwd, inst_done, illegal, halted;
  logic [15:0] num_inst;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code), .mem_ack(mem_ack),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .is_wwd(is_wwd),
    .inst_done(inst_done), .illegal(illegal), .halted(halted), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       is_wwd, inst_done, illegal, halted;
  } ctl_t;

  int          checks = 0;
  int          failures = 0;
  int          ncyc;
  int          rd_cnt;
  logic [15:0] m_cnt = '0;

  function automatic ctl_t cur();
    return {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, is_wwd,
            inst_done, illegal, halted};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One clock of the compare process: drive ack, sample at negedge, advance model count.
  task automatic step(input string nm, input logic ack, input ctl_t e);
    ctl_t act;
    mem_ack = ack;
    @(negedge clk);
    act = cur();
    if (act.mem_read) rd_cnt++;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d ctl act=%b exp=%b", nm, ncyc, act, e);
    end
    checks++;
    if (num_inst !== m_cnt) begin
      failures++;
      $display("FAIL %s cyc=%0d num_inst act=%0d exp=%0d", nm, ncyc, num_inst, m_cnt);
    end
    @(posedge clk); #1;
    if (e.inst_done) m_cnt++;
    ncyc++;
  endtask

  // Model: walk one instruction through its phases with the given wait states.
  task automatic run(input string nm, input logic [3:0] op, input logic [5:0] fn,
                     input int ifw, input int memw, input logic jack, input int lat,
                     input bit abort = 1'b0);
    ctl_t e;
    bit rtype, imm, mem_op, br, fn_ok;
    rtype  = (op == 4'd15) && (fn < 6'd8);
    imm    = (op >= 4'd4) && (op <= 4'd6);
    mem_op = (op == 4'd7) || (op == 4'd8);
    br     = (op <= 4'd3);
    fn_ok  = rtype || fn == 6'd25 || fn == 6'd26 || fn == 6'd28 || fn == 6'd29;
    ncyc = 0;
    opcode = 4'hB; func_code = 6'h3F;
    e = '0; e.mem_read = 1'b1;
    for (int i = 0; i < ifw; i++) step({nm, "_if"}, 1'b0, e);
    e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'd1;
    step({nm, "_if"}, 1'b1, e);
    opcode = op; func_code = fn;
    e = '0; e.alu_src_b = 2'd3;
    if (op == 4'd9 || op == 4'd10) begin
      e.pc_write = 1'b1; e.pc_source = 2'd2; e.inst_done = 1'b1;
    end
    if (op == 4'd15 && (fn == 6'd25 || fn == 6'd26)) begin
      e.pc_write = 1'b1; e.pc_source = 2'd3; e.inst_done = 1'b1;
    end
    if (op == 4'd10 || (op == 4'd15 && fn == 6'd26)) begin
      e.reg_write = 1'b1; e.reg_dst = 2'd2;
    end
    if (op == 4'd15 && fn == 6'd28) begin e.is_wwd = 1'b1; e.inst_done = 1'b1; end
    if (op == 4'd15 && fn == 6'd29) e.inst_done = 1'b1;
    if ((op >= 4'd11 && op <= 4'd14) || (op == 4'd15 && !fn_ok)) begin
      e.illegal = 1'b1; e.inst_done = 1'b1;
    end
    step({nm, "_id"}, jack, e);
    if (!e.inst_done) begin
      e = '0; e.alu_src_a = 1'b1;
      if (rtype) e.alu_op = 2'd2;
      if (imm) begin e.alu_src_b = 2'd2; e.alu_op = 2'd3; end
      if (mem_op) e.alu_src_b = 2'd2;
      if (br) begin
        e.alu_op = 2'd1; e.pc_write_cond = 1'b1; e.pc_source = 2'd1; e.inst_done = 1'b1;
      end
      step({nm, "_ex"}, jack, e);
      if (!br) begin
        if (mem_op) begin
          e = '0; e.i_or_d = 1'b1;
          e.mem_read = (op == 4'd7); e.mem_write = (op == 4'd8);
          for (int i = 0; i < memw; i++) step({nm, "_mem"}, 1'b0, e);
          if (abort) return;
          e.inst_done = (op == 4'd8);
          step({nm, "_mem"}, 1'b1, e);
        end
        if (op != 4'd8) begin
          e = '0; e.reg_write = 1'b1; e.reg_dst = rtype ? 2'd1 : 2'd0;
          e.mem_to_reg = (op == 4'd7); e.inst_done = 1'b1;
          step({nm, "_wb"}, jack, e);
        end
      end
    end
    chk({nm, "_latency"}, ncyc, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ctl_t eh;
    reset = 1'b1; mem_ack = 1'b1; opcode = '0; func_code = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", int'(cur()), 0);
    chk("reset_num_inst", int'(num_inst), 0);
    reset = 1'b0; mem_ack = 1'b0;

    run("ADD", 4'd15, 6'd0, 0, 0, 1'b0, 4);
    chk("add_num_inst", int'(num_inst), 1);
    rd_cnt = 0;
    run("LWD", 4'd7, 6'd0, 3, 3, 1'b1, 11);
    chk("lwd_mem_read_cycles", rd_cnt, 8);
    run("JAL", 4'd10, 6'd0, 0, 0, 1'b1, 2);
    run("WWD", 4'd15, 6'd28, 0, 0, 1'b0, 2);
    chk("jal_wwd_num_inst", int'(num_inst), 4);
    run("BEQ", 4'd1, 6'd0, 0, 0, 1'b1, 3);
    run("ADI", 4'd4, 6'd5, 1, 0, 1'b0, 5);
    run("ORI", 4'd5, 6'd0, 0, 0, 1'b1, 4);
    run("LHI", 4'd6, 6'd0, 0, 0, 1'b0, 4);
    run("RT7", 4'd15, 6'd7, 0, 0, 1'b1, 4);
    run("JPR", 4'd15, 6'd25, 0, 0, 1'b0, 2);
    run("JRL", 4'd15, 6'd26, 0, 0, 1'b1, 2);
    run("SWD", 4'd8, 6'd0, 2, 1, 1'b1, 7);
    run("ILL_OP", 4'd12, 6'd0, 0, 0, 1'b0, 2);
    run("ILL_FN", 4'd15, 6'd27, 0, 0, 1'b0, 2);
    run("JMP", 4'd9, 6'd0, 0, 0, 1'b1, 2);
    run("BLZ", 4'd3, 6'd0, 0, 0, 1'b0, 3);
    chk("mid_num_inst", int'(num_inst), 16);

    run("SWD_RST", 4'd8, 6'd0, 0, 2, 1'b0, 0, 1'b1);
    chk("pre_reset_mem_write", int'(mem_write), 1);
    reset = 1'b1; #1;
    chk("reset_mem_write_drop", int'(mem_write), 0);
    chk("reset_mid_ctl", int'(cur()), 0);
    chk("reset_mid_num_inst", int'(num_inst), 0);
    @(posedge clk); #1;
    reset = 1'b0; m_cnt = '0;
    run("ADD2", 4'd15, 6'd3, 0, 0, 1'b0, 4);
    chk("post_reset_num_inst", int'(num_inst), 1);

    run("HLT", 4'd15, 6'd29, 0, 0, 1'b0, 2);
    eh = '0; eh.halted = 1'b1;
    for (int i = 0; i < 10; i++) step("halt", (i % 2) == 0, eh);
    chk("halt_num_inst", int'(num_inst), 2);
    chk("halt_sticky", int'(halted), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
